// File: rtl/err_pkg.sv
// Shared types and constants for the line-follower error sampler.
package err_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_RDY,
      CALC,
      OUT,
      WAIT_TMR
   } err_state_t;

   localparam int NUM_CH = 6;
   localparam logic [2:0] CH_LAST = 3'(NUM_CH - 1);

   localparam int ACC_W = 15;

   localparam logic SIDE_L = 1'b0;
   localparam logic SIDE_R = 1'b1;

   // Weights expressed as left-shift amounts: outer x4, mid x2, inner x1.
   localparam logic [1:0] W_OUTER = 2'd2;
   localparam logic [1:0] W_MID   = 2'd1;
   localparam logic [1:0] W_INNER = 2'd0;

   localparam int ERR_MAX = 511;
   localparam int ERR_MIN = -512;

   function automatic logic [1:0] ch_wshift(input logic [2:0] ch);
      case (ch)
         3'd0, 3'd5: return W_OUTER;
         3'd1, 3'd4: return W_MID;
         default:    return W_INNER;
      endcase
   endfunction

   function automatic logic ch_side(input logic [2:0] ch);
      return (ch >= 3'd3) ? SIDE_R : SIDE_L;
   endfunction

endpackage

// File: rtl/err_sat10.sv
// Combinational clamp of a 16-bit signed value into the 10-bit signed error range.
module err_sat10
   import err_pkg::*;
(
   input  logic signed [15:0] din,
   output logic        [9:0]  dout
);

   localparam logic signed [15:0] MAX16 = 16'(ERR_MAX);
   localparam logic signed [15:0] MIN16 = 16'(ERR_MIN);

   always_comb begin
      dout = din[9:0];
      if (din > MAX16)
         dout = 10'h1FF;
      else if (din < MIN16)
         dout = 10'h200;
   end

endmodule

// File: rtl/err_sampler.sv
// Sweeps six IR channels through the A2D each sample period and produces a
// saturated right-minus-left steering error for the PID stages.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | disabled; waits for en, then starts a sweep
// REQ      | cnv_req pulse for the current chnl
// WAIT_RDY | waits for cnv_rdy, accumulates result, guarded by timeout
// CALC     | registers the shifted and saturated difference
// OUT      | publishes err_sat with err_vld, clears err_fault
// WAIT_TMR | waits for the period timer before the next sweep
module err_sampler
   import err_pkg::*;
#(
   parameter int PERIOD  = 50000,
   parameter int TIMEOUT = 1024,
   parameter int SHIFT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        cnv_req,
   output logic [2:0]  chnl,
   input  logic        cnv_rdy,
   input  logic [11:0] res,
   output logic [9:0]  err_sat,
   output logic        err_vld,
   output logic        err_fault
);

   localparam int TMR_W  = $clog2(PERIOD + 1);
   localparam int TOUT_W = $clog2(TIMEOUT + 1);

   err_state_t         state;
   logic [TMR_W-1:0]   tmr;
   logic [TOUT_W-1:0]  tout;
   logic [ACC_W-1:0]   sum_l;
   logic [ACC_W-1:0]   sum_r;
   logic [ACC_W-1:0]   res_w;
   logic signed [15:0] diff;
   logic signed [15:0] scaled;
   logic [9:0]         sat_out;
   logic [9:0]         err_calc;
   logic               tout_hit;
   logic               start_sweep;

   assign res_w  = ACC_W'(res) << ch_wshift(chnl);
   assign diff   = signed'({1'b0, sum_r}) - signed'({1'b0, sum_l});
   assign scaled = diff >>> SHIFT;

   err_sat10 u_sat (
      .din  (scaled),
      .dout (sat_out)
   );

   assign tout_hit = (state == WAIT_RDY) && !cnv_rdy && (tout == '0);

   // An overrunning sweep leaves the timer parked at zero, so the next
   // sweep launches straight out of OUT or the timeout abort.
   always_comb begin
      start_sweep = 1'b0;
      if (en) begin
         if (state == IDLE)
            start_sweep = 1'b1;
         else if ((state == OUT || state == WAIT_TMR || tout_hit) && tmr == '0)
            start_sweep = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tmr       <= '0;
         tout      <= '0;
         sum_l     <= '0;
         sum_r     <= '0;
         err_calc  <= '0;
         cnv_req   <= 1'b0;
         chnl      <= '0;
         err_sat   <= '0;
         err_vld   <= 1'b0;
         err_fault <= 1'b0;
      end else begin
         cnv_req <= 1'b0;
         err_vld <= 1'b0;
         if (tmr != '0)
            tmr <= tmr - 1'b1;

         if (!en) begin
            state <= IDLE;
            chnl  <= '0;
         end else begin
            case (state)
               IDLE: ;
               REQ: begin
                  tout  <= TOUT_W'(TIMEOUT - 1);
                  state <= WAIT_RDY;
               end
               WAIT_RDY: begin
                  if (cnv_rdy) begin
                     if (ch_side(chnl) == SIDE_R)
                        sum_r <= sum_r + res_w;
                     else
                        sum_l <= sum_l + res_w;
                     if (chnl == CH_LAST) begin
                        chnl  <= '0;
                        state <= CALC;
                     end else begin
                        chnl    <= chnl + 1'b1;
                        cnv_req <= 1'b1;
                        state   <= REQ;
                     end
                  end else if (tout == '0) begin
                     err_fault <= 1'b1;
                     chnl      <= '0;
                     state     <= WAIT_TMR;
                  end else begin
                     tout <= tout - 1'b1;
                  end
               end
               CALC: begin
                  err_calc <= sat_out;
                  state    <= OUT;
               end
               OUT: begin
                  err_sat   <= err_calc;
                  err_vld   <= 1'b1;
                  err_fault <= 1'b0;
                  state     <= WAIT_TMR;
               end
               WAIT_TMR: ;
               default: state <= IDLE;
            endcase

            if (start_sweep) begin
               tmr     <= TMR_W'(PERIOD - 1);
               sum_l   <= '0;
               sum_r   <= '0;
               chnl    <= '0;
               cnv_req <= 1'b1;
               state   <= REQ;
            end
         end
      end
   end

endmodule

// File: tb/tb_err_sampler.sv
// Randomised bench for err_sampler with a behavioural A2D and an arithmetic error model.
module tb_err_sampler;

   localparam int PER  = 1500;
   localparam int TOUT = 1024;

   typedef int vals_t [6];

   logic        clk_tb = 1'b0;
   logic        rst;
   logic        en;
   logic        cnv_req;
   logic [2:0]  chnl;
   logic        cnv_rdy;
   logic [11:0] res;
   logic [9:0]  err_sat;
   logic        err_vld;
   logic        err_fault;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   logic req_d = 1'b0;

   always #5 clk_tb = ~clk_tb;
   always @(posedge clk_tb) cyc <= cyc + 1;

   err_sampler #(.PERIOD(PER), .TIMEOUT(TOUT), .SHIFT(2)) dut (
      .clk       (clk_tb),
      .rst       (rst),
      .en        (en),
      .cnv_req   (cnv_req),
      .chnl      (chnl),
      .cnv_rdy   (cnv_rdy),
      .res       (res),
      .err_sat   (err_sat),
      .err_vld   (err_vld),
      .err_fault (err_fault)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_tb) begin
      if (cnv_req) chk("req_1cyc", 32'(req_d), 32'd0);
      req_d <= cnv_req;
   end

   // Weighted right-minus-left, floor-divided by 4, clamped to 10-bit signed.
   function automatic logic [9:0] model(input vals_t v);
      int l, r, d, s;
      l = 4 * v[0] + 2 * v[1] + v[2];
      r = v[3] + 2 * v[4] + 4 * v[5];
      d = r - l;
      s = (d >= 0) ? d / 4 : -((-d + 3) / 4);
      if (s > 511)  s = 511;
      if (s < -512) s = -512;
      return 10'(s);
   endfunction

   function automatic int rval();
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return 4095;
         default: return int'($urandom_range(0, 4095));
      endcase
   endfunction

   task automatic wait_req(output bit ok);
      int n = 0;
      while (!cnv_req && n < 4000) begin
         @(negedge clk_tb);
         n++;
      end
      ok = cnv_req;
      if (!ok) chk("req_timeout", 32'd0, 32'd1);
   endtask

   task automatic serve(input int ch, input int val, input int dly, input bit stray, output int t_req);
      bit ok;
      wait_req(ok);
      t_req = cyc;
      if (ok) begin
         chk("chnl", 32'(chnl), 32'(ch));
         if (stray) begin
            cnv_rdy = 1'b1;
            res     = 12'hFFF;
         end
         repeat (1 + dly) begin
            @(negedge clk_tb);
            cnv_rdy = 1'b0;
         end
         cnv_rdy = 1'b1;
         res     = 12'(val);
         @(negedge clk_tb);
         cnv_rdy = 1'b0;
      end
   endtask

   task automatic sweep(input vals_t v, input bit fast, input bit strays, output int t0);
      logic [9:0] e;
      int t, n;
      e = model(v);
      t0 = 0;
      for (int i = 0; i < 6; i++) begin
         serve(i, v[i], fast ? 0 : int'($urandom_range(0, 3)),
               strays && ($urandom_range(0, 3) == 0), t);
         if (i == 0) t0 = t;
      end
      n = 0;
      while (!err_vld && n < 10) begin
         @(negedge clk_tb);
         n++;
      end
      chk("vld_seen", 32'(err_vld), 32'd1);
      if (fast) chk("latency", 32'(cyc - t0), 32'd14);
      chk("err_sat", 32'(err_sat), 32'(e));
      chk("fault_clr", 32'(err_fault), 32'd0);
      @(negedge clk_tb);
      chk("vld_1cyc", 32'(err_vld), 32'd0);
   endtask

   initial begin
      vals_t v;
      int t_a, t_b, t, vld_cnt;
      bit ok;
      logic [9:0] prev;

      rst = 1'b1; en = 1'b0; cnv_rdy = 1'b0; res = '0;
      repeat (3) @(negedge clk_tb);
      chk("rst_sat",   32'(err_sat),   32'd0);
      chk("rst_vld",   32'(err_vld),   32'd0);
      chk("rst_req",   32'(cnv_req),   32'd0);
      chk("rst_chnl",  32'(chnl),      32'd0);
      chk("rst_fault", 32'(err_fault), 32'd0);
      rst = 1'b0;
      en  = 1'b1;

      v = '{100, 100, 100, 100, 100, 100};
      sweep(v, 1'b1, 1'b0, t_a);
      v = '{0, 0, 0, 400, 0, 0};
      sweep(v, 1'b1, 1'b0, t_b);
      chk("period", 32'(t_b - t_a), 32'(PER));
      v = '{0, 0, 0, 0, 0, 1024};
      sweep(v, 1'b1, 1'b0, t_a);
      chk("period", 32'(t_a - t_b), 32'(PER));
      v = '{4095, 0, 0, 0, 0, 0};
      sweep(v, 1'b1, 1'b0, t_b);

      // Stray ready while waiting on the period timer.
      @(negedge clk_tb);
      cnv_rdy = 1'b1; res = 12'hFFF;
      @(negedge clk_tb);
      cnv_rdy = 1'b0;
      chk("stray_req",  32'(cnv_req), 32'd0);
      chk("stray_chnl", 32'(chnl),    32'd0);
      for (int i = 0; i < 6; i++) v[i] = rval();
      sweep(v, 1'b1, 1'b0, t_a);
      chk("period_stray", 32'(t_a - t_b), 32'(PER));

      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 6; i++) v[i] = rval();
         sweep(v, 1'b0, 1'b1, t);
      end

      // Timeout on ch2.
      for (int i = 0; i < 6; i++) v[i] = rval();
      serve(0, v[0], 0, 1'b0, t);
      serve(1, v[1], 0, 1'b0, t);
      wait_req(ok);
      chk("to_chnl", 32'(chnl), 32'd2);
      prev = err_sat;
      vld_cnt = 0;
      for (int k = 1; k <= TOUT + 1; k++) begin
         @(negedge clk_tb);
         if (err_vld) vld_cnt++;
         if (k == TOUT) chk("fault_early", 32'(err_fault), 32'd0);
         if (k == TOUT + 1) begin
            chk("fault_set", 32'(err_fault), 32'd1);
            chk("to_chnl0",  32'(chnl),      32'd0);
         end
      end
      chk("to_no_vld", 32'(vld_cnt), 32'd0);
      chk("to_hold",   32'(err_sat), 32'(prev));

      // Enable drop in WAIT_RDY on ch4, coincident with cnv_rdy.
      for (int i = 0; i < 6; i++) v[i] = rval();
      for (int i = 0; i < 4; i++) serve(i, v[i], 0, 1'b0, t);
      wait_req(ok);
      chk("drop_chnl", 32'(chnl), 32'd4);
      @(negedge clk_tb);
      en = 1'b0; cnv_rdy = 1'b1; res = 12'hFFF;
      @(negedge clk_tb);
      cnv_rdy = 1'b0;
      chk("drop_req",   32'(cnv_req),   32'd0);
      chk("drop_chnl0", 32'(chnl),      32'd0);
      chk("drop_fault", 32'(err_fault), 32'd1);
      chk("drop_sat",   32'(err_sat),   32'(prev));
      vld_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_tb);
         if (err_vld || cnv_req) vld_cnt++;
      end
      chk("idle_quiet", 32'(vld_cnt), 32'd0);
      en = 1'b1;
      @(negedge clk_tb);
      chk("restart_req",  32'(cnv_req), 32'd1);
      chk("restart_chnl", 32'(chnl),    32'd0);
      for (int i = 0; i < 6; i++) v[i] = rval();
      sweep(v, 1'b1, 1'b0, t);

      // Reset mid-sweep.
      v = '{0, 0, 0, 400, 0, 0};
      sweep(v, 1'b1, 1'b0, t);
      for (int i = 0; i < 3; i++) serve(i, 50, 0, 1'b0, t);
      wait_req(ok);
      @(negedge clk_tb);
      rst = 1'b1;
      @(negedge clk_tb);
      chk("mrst_sat",   32'(err_sat),   32'd0);
      chk("mrst_vld",   32'(err_vld),   32'd0);
      chk("mrst_req",   32'(cnv_req),   32'd0);
      chk("mrst_chnl",  32'(chnl),      32'd0);
      chk("mrst_fault", 32'(err_fault), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) v[i] = rval();
      sweep(v, 1'b1, 1'b0, t);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/err_sampler.md
# err_sampler

Upstream error-generation stage of the line-follower PID. On a fixed sample period, the block sweeps six IR sensor channels through the A2D converter interface using a request/ready handshake. It forms a signed, position-weighted right-minus-left error, scales it, saturates it to 10 bits, and delivers it as `err_sat` with a one-cycle `err_vld` strobe. The Dterm stage and the P and I stages consume `err_sat`/`err_vld` directly.

## Interface
- `PERIOD`, 50000: clocks from one sweep start to the next.
- `TIMEOUT`, 1024: maximum clocks spent in WAIT_RDY before the sweep aborts.
- `SHIFT`, 2: arithmetic right shift applied to the raw difference before saturation.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: sampling enable.
- `cnv_req` output 1: one-cycle pulse that starts a conversion on `chnl`.
- `chnl` output 3: channel under conversion (0..5), held stable from `cnv_req` until `cnv_rdy` is accepted.
- `cnv_rdy` input 1: one-cycle pulse; `res` is valid in that cycle.
- `res` input 12: unsigned conversion result.
- `err_sat` output 10: signed saturated error; holds its value between updates.
- `err_vld` output 1: one-cycle strobe, coincident with each new `err_sat`.
- `err_fault` output 1: sticky conversion-timeout flag.

## Operation
- Channel map and weights:
  - Left side: ch0 outer ×4, ch1 mid ×2, ch2 inner ×1.
  - Right side: ch3 inner ×1, ch4 mid ×2, ch5 outer ×4.
- Accumulators:
  - `sumL` and `sumR` are 15-bit unsigned; maximum is 7×4095 = 28665.
  - Weights are applied as left shifts.
  - Both accumulators clear at sweep start.
- Arithmetic:
  - `diff = sumR − sumL`, 16-bit signed.
  - `scaled = diff >>> SHIFT`, arithmetic shift.
  - Saturate `scaled` to −512..+511: above 511 gives 10'h1FF; below −512 gives 10'h200.
- FSM states:
  - IDLE: when `en`=1, load the period timer and go to REQ with `chnl`=0.
  - REQ: pulse `cnv_req` for one cycle, then go to WAIT_RDY.
  - WAIT_RDY:
    - On `cnv_rdy`, accumulate `res` into the side and weight selected by `chnl`.
    - If `chnl`=5, go to CALC. Otherwise increment `chnl` and go to REQ.
    - After TIMEOUT clocks without `cnv_rdy`, set `err_fault`, reset `chnl` to 0 and go to WAIT_TMR. No `err_vld` is produced.
  - CALC: register the difference, shift and saturation, then go to OUT.
  - OUT: update `err_sat`, pulse `err_vld`, clear `err_fault`, then go to WAIT_TMR.
  - WAIT_TMR: when the period timer expires, go to REQ.
- Period timer:
  - Counts PERIOD clocks from sweep start.
  - If a sweep overruns the period, the next sweep starts immediately after OUT, or after the timeout abort.
- Enable deassertion: `en`=0 in any state forces IDLE on the next edge. The partial sweep is discarded, `err_sat` and `err_fault` are retained, and no `err_vld` is produced.
- Stray `cnv_rdy`: ignored outside WAIT_RDY, including in the REQ cycle itself.

## Timing
- Reset values:
  - `err_sat`=0, `err_vld`=0, `cnv_req`=0, `chnl`=0, `err_fault`=0.
  - FSM in IDLE; accumulators and timers cleared.
- Reset mid-sweep: takes effect on the next edge with the same values and overrides every other event.
- Handshake:
  - `cnv_req` lasts exactly one cycle.
  - The earliest accepted `cnv_rdy` is the cycle after `cnv_req`.
  - The next `cnv_req` follows one cycle after `cnv_rdy`.
- Latency:
  - Final ch5 `cnv_rdy` at edge N.
  - CALC at edge N+1.
  - `err_sat` updates and `err_vld` is high in the cycle after edge N+2.
- Simultaneous `en` falling and `cnv_rdy` in the same cycle: `en` wins; the sample is not accumulated.
- Minimum sweep with an A2D that answers immediately: 6×2 + 2 = 14 clocks from the first `cnv_req` to `err_vld`.

## Structure
- Package `err_pkg` contains:
  - the state enum `err_state_t` (IDLE, REQ, WAIT_RDY, CALC, OUT, WAIT_TMR);
  - the channel-weight and side constants;
  - `ERR_MAX` = 511 and `ERR_MIN` = −512;
  - `NUM_CH` = 6.
- One sub-module, `err_sat10`: a combinational 16-bit signed to 10-bit signed saturator, instantiated in front of the CALC register.
- The FSM, period timer, timeout counter and accumulators live in `err_sampler`.

## Test plan
- Balanced input: all six channels return 100, SHIFT=2, then check:
  - `err_sat`=10'h000;
  - `err_vld` asserted for exactly one cycle;
  - 6 `cnv_req` pulses observed for `chnl` 0..5, in order.
- Positive in-range and positive saturation:
  - ch3=400, all other channels 0 → `err_sat`=10'h064 (100).
  - ch5=1024, all other channels 0 → `err_sat`=10'h1FF.
- Negative saturation: ch0=4095, all other channels 0 gives a scaled value of −4095, so `err_sat`=10'h200.
- Timeout: withhold `cnv_rdy` on ch2, then check:
  - `err_fault` rises after 1024 clocks;
  - no `err_vld`, and `err_sat` unchanged;
  - the next good sweep clears `err_fault`.
- Enable drop and stray ready:
  - Drop `en` during WAIT_RDY on ch4 → FSM in IDLE next cycle, no `err_vld`.
  - Re-raise `en` → sweep restarts at `chnl`=0.
  - A stray `cnv_rdy` in WAIT_TMR is ignored.
- Reset and period timing:
  - Assert `rst` mid-sweep → all outputs 0 the following cycle.
  - Sweep starts are spaced exactly PERIOD clocks apart when the A2D answers promptly.
